// File: rtl/pll_reset_pkg.sv
// Shared types and constants for the PLL reset sequencer.
// The optional lock-loss counter is built only when LOCK_LOSS_COUNT_EN is defined.
package pll_reset_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } seq_state_e;

  localparam int unsigned LOCK_LOSS_W = 8;
  localparam logic [LOCK_LOSS_W-1:0] LOCK_LOSS_MAX = 8'hFF;

  typedef struct packed {
    logic sys_reset;
    logic panel_enable;
    logic ready;
  } seq_outs_t;

  // Output values that belong to a given state.
  function automatic seq_outs_t outs_for(input seq_state_e s);
    seq_outs_t o;
    o.sys_reset    = (s == WAIT_LOCK) || (s == STABLE);
    o.panel_enable = (s == RUN);
    o.ready        = (s == RUN);
    return o;
  endfunction

  // Increment that holds at the maximum value.
  function automatic logic [LOCK_LOSS_W-1:0] sat_inc(input logic [LOCK_LOSS_W-1:0] v);
    return (v == LOCK_LOSS_MAX) ? v : v + LOCK_LOSS_W'(1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer with synchronous active-high reset.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Qualifies PLL lock, then releases system reset and enables the LED panel in order.
// Define LOCK_LOSS_COUNT_EN to add the saturating lock_loss_count output.
module pll_reset_sequencer
  import pll_reset_pkg::*;
#(
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned RELEASE_CYCLES     = 16,
  parameter int unsigned CNT_W              =
    $clog2((LOCK_STABLE_CYCLES > RELEASE_CYCLES) ? LOCK_STABLE_CYCLES : RELEASE_CYCLES) + 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pll_locked,
  output logic       sys_reset,
  output logic       panel_enable,
  output logic       ready,
  output logic [1:0] state
`ifdef LOCK_LOSS_COUNT_EN
  ,
  output logic [LOCK_LOSS_W-1:0] lock_loss_count
`endif
);

  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(RELEASE_CYCLES - 1);

  logic             lk;
  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  seq_outs_t        outs_q, outs_d;

  sync_2ff u_lock_sync (
    .clk_i (clock),
    .rst_i (reset),
    .d_i   (pll_locked),
    .q_o   (lk)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
      outs_q  <= outs_for(WAIT_LOCK);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      outs_q  <= outs_d;
    end
  end

  // Loss of lock always wins over a terminal-count advance; the counter restarts from zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      WAIT_LOCK: begin
        if (lk) begin
          state_d = STABLE;
          cnt_d   = '0;
        end
      end
      STABLE: begin
        if (!lk) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = RELEASE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RELEASE: begin
        if (!lk) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == RELEASE_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RUN: begin
        if (!lk) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
    // Outputs are registered from the next state so they change with it.
    outs_d = outs_for(state_d);
  end

  assign sys_reset    = outs_q.sys_reset;
  assign panel_enable = outs_q.panel_enable;
  assign ready        = outs_q.ready;
  assign state        = 2'(state_q);

`ifdef LOCK_LOSS_COUNT_EN
  logic                   loss_event_c;
  logic [LOCK_LOSS_W-1:0] loss_cnt_q;

  // Only a drop of lk out of a locked-side state counts as a loss.
  assign loss_event_c = (state_q != WAIT_LOCK) && !lk;

  always_ff @(posedge clock) begin
    if (reset) begin
      loss_cnt_q <= '0;
    end else if (loss_event_c) begin
      loss_cnt_q <= sat_inc(loss_cnt_q);
    end
  end

  assign lock_loss_count = loss_cnt_q;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed self-checking bench for pll_reset_sequencer (LOCK_STABLE_CYCLES=8, RELEASE_CYCLES=4).
module tb_pll_reset_sequencer;

  localparam int unsigned LS = 8;
  localparam int unsigned RC = 4;

  logic       clock;
  logic       reset;
  logic       pll_locked;
  logic       sys_reset;
  logic       panel_enable;
  logic       ready;
  logic [1:0] state;
`ifdef LOCK_LOSS_COUNT_EN
  logic [7:0] lock_loss_count;
`endif

  int total;
  int bad;

  typedef struct {
    logic       rst;
    logic       lock;
    int         n;
    logic [1:0] st;
    logic       sr;
    logic       pe;
    logic       rdy;
  } vec_t;

  vec_t vecs[$];

  pll_reset_sequencer #(
    .LOCK_STABLE_CYCLES (LS),
    .RELEASE_CYCLES     (RC)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .pll_locked   (pll_locked),
    .sys_reset    (sys_reset),
    .panel_enable (panel_enable),
    .ready        (ready),
    .state        (state)
`ifdef LOCK_LOSS_COUNT_EN
    ,
    .lock_loss_count (lock_loss_count)
`endif
  );

  initial clock = 1'b0;
  always #4 clock = ~clock;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [1:0] st, input logic sr,
                            input logic pe, input logic rdy);
    check({tag, ".state"}, 32'(state), 32'(st));
    check({tag, ".sys_reset"}, 32'(sys_reset), 32'(sr));
    check({tag, ".panel_enable"}, 32'(panel_enable), 32'(pe));
    check({tag, ".ready"}, 32'(ready), 32'(rdy));
  endtask

  task automatic apply(input logic r, input logic l, input int n);
    reset      = r;
    pll_locked = l;
    step(n);
  endtask

  function automatic vec_t mk(input logic r, input logic l, input int n, input logic [1:0] st,
                              input logic sr, input logic pe, input logic rdy);
    vec_t v;
    v.rst = r; v.lock = l; v.n = n; v.st = st; v.sr = sr; v.pe = pe; v.rdy = rdy;
    return v;
  endfunction

  initial begin
    total      = 0;
    bad        = 0;
    reset      = 1'b1;
    pll_locked = 1'b0;

    // Power-up: edge 1 is the first edge after reset release.
    vecs.push_back(mk(1, 1, 5, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 2, 0, 1, 0, 0));   // edge 2: lk just arrived
    vecs.push_back(mk(0, 1, 1, 1, 1, 0, 0));   // edge 3: STABLE
    vecs.push_back(mk(0, 1, 7, 1, 1, 0, 0));   // edge 10
    vecs.push_back(mk(0, 1, 1, 2, 0, 0, 0));   // edge 11: sys_reset falls
    vecs.push_back(mk(0, 1, 3, 2, 0, 0, 0));   // edge 14
    vecs.push_back(mk(0, 1, 1, 3, 0, 1, 1));   // edge 15: RUN
    vecs.push_back(mk(0, 1, 10, 3, 0, 1, 1));
    // Lock loss in RUN, then re-lock.
    vecs.push_back(mk(0, 0, 1, 3, 0, 1, 1));
    vecs.push_back(mk(0, 0, 1, 3, 0, 1, 1));
    vecs.push_back(mk(0, 0, 1, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 2, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 7, 1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 1, 2, 0, 0, 0));
    vecs.push_back(mk(0, 1, 3, 2, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 3, 0, 1, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].rst, vecs[i].lock, vecs[i].n);
      check_outs($sformatf("vec%0d", i), vecs[i].st, vecs[i].sr, vecs[i].pe, vecs[i].rdy);
    end

    // Lock glitch after the 5th STABLE cycle: no partial credit survives.
    apply(1, 1, 2);
    apply(0, 1, 3);
    check_outs("glitch.enter", 1, 1, 0, 0);
    apply(0, 1, 4);
    apply(0, 0, 3);
    check_outs("glitch.drop", 0, 1, 0, 0);
    apply(0, 1, 2);
    check_outs("glitch.wait", 0, 1, 0, 0);
    apply(0, 1, 1);
    check_outs("glitch.restable", 1, 1, 0, 0);
    apply(0, 1, 7);
    check_outs("glitch.fullcount", 1, 1, 0, 0);
    apply(0, 1, 1);
    check_outs("glitch.release", 2, 0, 0, 0);

    // Synchronous reset while in RELEASE with cnt=2.
    apply(1, 1, 2);
    apply(0, 1, 11);
    check_outs("rstrel.release", 2, 0, 0, 0);
    apply(0, 1, 2);
    apply(1, 1, 1);
    check_outs("rstrel.reset", 0, 1, 0, 0);
    apply(0, 1, 3);
    check_outs("rstrel.stable", 1, 1, 0, 0);
    apply(0, 1, 7);
    check_outs("rstrel.count", 1, 1, 0, 0);
    apply(0, 1, 1);
    check_outs("rstrel.again", 2, 0, 0, 0);

    // lk falls exactly on the STABLE terminal-count cycle.
    apply(1, 1, 2);
    apply(0, 1, 8);
    check_outs("simul.pre", 1, 1, 0, 0);
    apply(0, 0, 2);
    check_outs("simul.tc", 1, 1, 0, 0);
    for (int k = 0; k < 5; k++) begin
      apply(0, 0, 1);
      check_outs($sformatf("simul.after%0d", k), 0, 1, 0, 0);
    end

`ifdef LOCK_LOSS_COUNT_EN
    apply(1, 0, 2);
    check("llc.reset", 32'(lock_loss_count), 32'd0);
    for (int k = 0; k < 10; k++) begin
      apply(0, 1, 1);
      apply(0, 0, 1);
    end
    apply(0, 0, 4);
    check("llc.ten", 32'(lock_loss_count), 32'd10);
    apply(0, 0, 6);
    check("llc.waitlock_no_count", 32'(lock_loss_count), 32'd10);
    for (int k = 0; k < 250; k++) begin
      apply(0, 1, 1);
      apply(0, 0, 1);
    end
    apply(0, 0, 4);
    check("llc.saturate", 32'(lock_loss_count), 32'd255);
    apply(1, 0, 1);
    check("llc.cleared", 32'(lock_loss_count), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Sits directly downstream of the board PLL (125 MHz `clock` plus `panel_clock`, with `locked`).
- Qualifies the PLL lock indication and releases the system reset only after lock has been stable for a programmable time.
- Enables the LED-panel driver only after a further settling delay.
- On any loss of lock it re-asserts system reset and disables the panel. The sequence then restarts.

Parameters:
- LOCK_STABLE_CYCLES, 1024, consecutive synchronized-lock cycles required before `sys_reset` is released; must be >=1.
- RELEASE_CYCLES, 16, cycles between `sys_reset` release and `panel_enable` assertion; must be >=1.
- CNT_W, $clog2(max(LOCK_STABLE_CYCLES,RELEASE_CYCLES))+1, width of the shared delay counter.

Ports:
- clock  in  1  125 MHz PLL output clock.
- reset  in  1  external reset, synchronous, active-high.
- pll_locked  in  1  PLL lock indication, asynchronous to `clock`.
- sys_reset  out  1  system reset to the downstream logic, active-high, registered.
- panel_enable  out  1  enables the panel scan/driver, registered.
- ready  out  1  high only in RUN.
- state  out  2  current FSM state, for debug.
- lock_loss_count  out  8  saturating count of lock losses; present only with LOCK_LOSS_COUNT_EN.

Behaviour:
- Clocking and reset: one clock, `clock`. `reset` is synchronous and active-high.
- Values while `reset` is asserted and on the first edge after it:
  - sync flops 0;
  - state=WAIT_LOCK (2'd0);
  - counter 0;
  - sys_reset=1, panel_enable=0, ready=0, lock_loss_count=0.
- Synchronizer: `pll_locked` passes through 2 flops to give `lk`. `reset` clears both flops.
- FSM states: WAIT_LOCK=0, STABLE=1, RELEASE=2, RUN=3. Transitions:
  - WAIT_LOCK: if lk=1, go to STABLE with cnt=0.
  - STABLE:
    - if lk=0, go to WAIT_LOCK;
    - else if cnt==LOCK_STABLE_CYCLES-1, go to RELEASE with cnt=0;
    - else cnt++.
  - RELEASE:
    - if lk=0, go to WAIT_LOCK;
    - else if cnt==RELEASE_CYCLES-1, go to RUN;
    - else cnt++.
  - RUN: if lk=0, go to WAIT_LOCK.
- Outputs are registered and change on the same edge as the state they belong to:
  - sys_reset=1 in WAIT_LOCK and STABLE;
  - panel_enable=1 and ready=1 only in RUN;
  - there are no glitches on outputs.
- Latency: if `pll_locked` is first sampled high at edge 1:
  - lk=1 at edge 2;
  - STABLE entered at edge 3;
  - `sys_reset` falls at edge 3+LOCK_STABLE_CYCLES;
  - `panel_enable` rises at edge 3+LOCK_STABLE_CYCLES+RELEASE_CYCLES.
- Loss of lock: lk=0 in any state other than WAIT_LOCK gives state WAIT_LOCK, sys_reset=1 and panel_enable=0 on the next edge. The counter is cleared and timing restarts from zero; no partial credit is kept.
- Simultaneous events:
  - `reset` overrides everything.
  - lk=0 on the terminal-count cycle wins over the advance.
- `reset` mid-sequence, in any state, returns to reset values on the next edge.
- The counter never wraps. It is compared against parameter-1 and then cleared.

Optional Feature:
- Macro: LOCK_LOSS_COUNT_EN.
- When defined:
  - the `lock_loss_count` port exists;
  - it increments by 1 on each transition to WAIT_LOCK caused by lk=0 from STABLE, RELEASE or RUN;
  - it saturates at 255 and is cleared only by `reset`.
- When undefined, the port and its register are absent and behaviour is otherwise identical.

Decomposition:
- Package `pll_reset_pkg`:
  - state typedef (2-bit enum WAIT_LOCK/STABLE/RELEASE/RUN);
  - LOCK_LOSS_W=8 constant;
  - LOCK_LOSS_MAX=8'hFF constant.
- Sub-module `sync_2ff`: single-bit two-flop synchronizer with synchronous active-high reset, used for `pll_locked`.

Test Plan (bench parameters LOCK_STABLE_CYCLES=8, RELEASE_CYCLES=4):
- Power-up: hold `reset` for 5 cycles with pll_locked=1, then release (edge 1 = first edge after release) -> sys_reset falls at edge 11, panel_enable and ready rise at edge 15, state=3.
- Lock glitch during STABLE: `pll_locked` drops for 3 cycles after the 5th STABLE cycle -> state returns to 0, sys_reset stays 1, and the full 8-cycle count restarts after lk returns.
- Lock loss in RUN: drop `pll_locked` -> 2 edges later lk=0, then on the next edge sys_reset=1, panel_enable=0, state=0. Re-lock -> release after 8+4 cycles again.
- Synchronous reset asserted in RELEASE (cnt=2) -> next edge: sys_reset=1, panel_enable=0, state=0, counter 0.
- Simultaneous events: lk falls on the STABLE terminal-count cycle -> goes to WAIT_LOCK, sys_reset never deasserts.
- With LOCK_LOSS_COUNT_EN: 260 lock-loss events -> lock_loss_count saturates at 255; `reset` returns it to 0. A bounce inside WAIT_LOCK does not count.
